// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    TIMEOUT = 2'd2
  } perf_state_e;

  // Event channel assignment used by the cpu integration.
  localparam int CH_INST       = 0;
  localparam int CH_ICACHE_HIT = 1;
  localparam int CH_DCACHE_HIT = 2;
  localparam int CH_ICACHE_REQ = 3;
  localparam int CH_DCACHE_REQ = 4;
  localparam int CH_MEM_RD     = 5;
  localparam int CH_MEM_WR     = 6;
  localparam int CH_REG_WR     = 7;

endpackage

// File: rtl/perf_counter_cell.sv
// Single event counter with sticky overflow flag.
// Wraps on overflow by default; saturates when PERF_SATURATE_EN is defined.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             frz,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic             at_max;
  logic [CNT_W-1:0] nxt;

  assign at_max = &cnt;

  always_comb begin
`ifdef PERF_SATURATE_EN
    nxt = at_max ? cnt : cnt + CNT_W'(1);
`else
    nxt = cnt + CNT_W'(1);
`endif
  end

  // NOTE: state updates use non-blocking assignments so every cell samples
  // the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc && !frz) begin
      cnt <= nxt;
      if (at_max) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Event-statistics unit: NUM_CH event counters, a cycle counter, halt/watchdog
// freeze and a registered read port. Optional macro: PERF_SATURATE_EN.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ev_in,
  input  logic                         halt,
  input  logic                         clr,
  input  logic                         rd_en,
  input  logic [$clog2(NUM_CH+1)-1:0]  rd_addr,
  output logic [CNT_W-1:0]             rd_data,
  output logic                         rd_vld,
  output logic [NUM_CH:0]              ovf,
  output logic                         halted,
  output logic                         timeout
);

  localparam int               AW    = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

  perf_state_e      state, state_nxt;
  logic             frz;
  logic             wd_hit;
  logic [NUM_CH:0]  cell_inc;
  logic [CNT_W-1:0] cnt [NUM_CH+1];
  logic [CNT_W-1:0] rd_sel;

  // The top cell is the free-running cycle counter.
  assign cell_inc = {1'b1, ev_in};
  assign frz      = (state != RUN);

  for (genvar g = 0; g <= NUM_CH; g++) begin : g_cell
    perf_counter_cell #(.CNT_W(CNT_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cell_inc[g]),
      .frz   (frz),
      .clr   (clr),
      .cnt   (cnt[g]),
      .ovf   (ovf[g])
    );
  end

  // Fires when this cycle's tick brings the cycle count to the limit.
  assign wd_hit = (CYCLE_LIMIT != 0) && (cnt[NUM_CH] + CNT_W'(1) == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = RUN;
    end else if (state == RUN) begin
      if (halt)        state_nxt = HALTED;
      else if (wd_hit) state_nxt = TIMEOUT;
    end
  end

  assign halted  = (state == HALTED);
  assign timeout = (state == TIMEOUT);

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= NUM_CH; i++) begin
      if (rd_addr == AW'(i)) rd_sel = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) rd_data <= rd_sel;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model (dut_a: no watchdog) and directed watchdog checks (dut_b).
module tb_perf_counter_bank;

  localparam int NCH  = 4;
  localparam int MAXV = 255;
`ifdef PERF_SATURATE_EN
  localparam int WRAPV = 255;
`else
  localparam int WRAPV = 0;
`endif

  logic clk;
  int   n_pass = 0;
  int   n_chk  = 0;

  logic             rst_n_a, halt_a, clr_a, rd_en_a;
  logic [NCH-1:0]   ev_a;
  logic [2:0]       rd_addr_a;
  logic [7:0]       rd_data_a;
  logic             rd_vld_a, halted_a, timeout_a;
  logic [NCH:0]     ovf_a;

  logic             rst_n_b, halt_b, clr_b, rd_en_b;
  logic [NCH-1:0]   ev_b;
  logic [2:0]       rd_addr_b;
  logic [7:0]       rd_data_b;
  logic             rd_vld_b, halted_b, timeout_b;
  logic [NCH:0]     ovf_b;

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .CYCLE_LIMIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .ev_in(ev_a), .halt(halt_a), .clr(clr_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_vld(rd_vld_a),
    .ovf(ovf_a), .halted(halted_a), .timeout(timeout_a)
  );

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .CYCLE_LIMIT(20)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .ev_in(ev_b), .halt(halt_b), .clr(clr_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_vld(rd_vld_b),
    .ovf(ovf_b), .halted(halted_b), .timeout(timeout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for dut_a: plain integer tallies and freeze flags.
  int         mc [NCH+1];
  bit         mo [NCH+1];
  bit         m_halted  = 0;
  bit         m_timeout = 0;
  bit         m_rd_vld  = 0;
  logic [7:0] m_rd_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic bump(input int i);
    if (mc[i] == MAXV) begin
      mc[i] = WRAPV;
      mo[i] = 1'b1;
    end else begin
      mc[i] = mc[i] + 1;
    end
  endtask

  task automatic model_step();
    if (!rst_n_a) begin
      for (int i = 0; i <= NCH; i++) begin mc[i] = 0; mo[i] = 0; end
      m_halted = 0; m_timeout = 0; m_rd_vld = 0; m_rd_data = '0;
    end else begin
      m_rd_vld = rd_en_a;
      if (rd_en_a) m_rd_data = (int'(rd_addr_a) <= NCH) ? 8'(mc[rd_addr_a]) : 8'd0;
      if (clr_a) begin
        for (int i = 0; i <= NCH; i++) begin mc[i] = 0; mo[i] = 0; end
        m_halted = 0; m_timeout = 0;
      end else if (!m_halted && !m_timeout) begin
        for (int i = 0; i < NCH; i++) if (ev_a[i]) bump(i);
        bump(NCH);
        if (halt_a) m_halted = 1;
      end
    end
  endtask

  task automatic tick_a();
    logic [NCH:0] exp_ovf;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i <= NCH; i++) exp_ovf[i] = mo[i];
    check("a_halted",  32'(halted_a),  32'(m_halted));
    check("a_timeout", 32'(timeout_a), 32'(m_timeout));
    check("a_ovf",     32'(ovf_a),     32'(exp_ovf));
    check("a_rd_vld",  32'(rd_vld_a),  32'(m_rd_vld));
    check("a_rd_data", 32'(rd_data_a), 32'(m_rd_data));
  endtask

  task automatic read_a(input int addr, input int exp);
    rd_en_a = 1'b1; rd_addr_a = 3'(addr);
    tick_a();
    check("a_read_val", 32'(rd_data_a), 32'(exp));
    check("a_read_vld", 32'(rd_vld_a), 32'd1);
    rd_en_a = 1'b0;
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  task automatic read_b(input int addr, input int exp);
    rd_en_b = 1'b1; rd_addr_b = 3'(addr);
    tick_b();
    check("b_read_val", 32'(rd_data_b), 32'(exp));
    check("b_read_vld", 32'(rd_vld_b), 32'd1);
    rd_en_b = 1'b0;
  endtask

  initial begin
    logic [7:0] prev;
    rst_n_a = 0; halt_a = 0; clr_a = 0; rd_en_a = 0; ev_a = '0; rd_addr_a = '0;
    rst_n_b = 0; halt_b = 0; clr_b = 0; rd_en_b = 0; ev_b = '0; rd_addr_b = '0;

    // Reset state
    tick_a(); tick_a();
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_vld", 32'(rd_vld_a), 32'd0);
    rst_n_a = 1;

    // Ten events on ch0/ch2, then a halt cycle
    ev_a = 4'b0101;
    repeat (10) tick_a();
    ev_a = '0; halt_a = 1;
    tick_a();
    halt_a = 0;
    check("halt_enter", 32'(halted_a), 32'd1);
    read_a(0, 10); read_a(1, 0); read_a(2, 10); read_a(3, 0); read_a(4, 11);
    ev_a = 4'b1111;
    tick_a();
    ev_a = '0;
    read_a(0, 10);

    // clr while halted, then halt+clr together
    clr_a = 1; tick_a(); clr_a = 0;
    check("clr_halted", 32'(halted_a), 32'd0);
    read_a(4, 0); read_a(4, 1); read_a(0, 0);
    halt_a = 1; clr_a = 1; tick_a(); halt_a = 0; clr_a = 0;
    check("halt_clr_state", 32'(halted_a), 32'd0);
    read_a(4, 0);

    // 256 events on ch1 with the halt on the last one
    clr_a = 1; tick_a(); clr_a = 0;
    ev_a = 4'b0010;
    repeat (255) tick_a();
    halt_a = 1; tick_a(); halt_a = 0; ev_a = '0;
    check("ovf_bits", 32'(ovf_a), 32'b10010);
    read_a(1, WRAPV); read_a(4, WRAPV);

    // Out-of-range read, then back-to-back reads of a counting channel
    read_a(NCH + 1, 0);
    read_a(7, 0);
    clr_a = 1; tick_a(); clr_a = 0;
    ev_a = 4'b0001; rd_en_a = 1; rd_addr_a = 3'd0;
    tick_a();
    prev = rd_data_a;
    for (int k = 0; k < 5; k++) begin
      tick_a();
      check("b2b_step", 32'(rd_data_a - prev), 32'd1);
      prev = rd_data_a;
    end
    rd_en_a = 0; ev_a = '0;

    // Randomized traffic
    clr_a = 1; tick_a(); clr_a = 0;
    for (int k = 0; k < 400; k++) begin
      ev_a      = 4'($urandom);
      rd_en_a   = 1'($urandom);
      rd_addr_a = 3'($urandom_range(0, 7));
      halt_a    = ($urandom_range(0, 39) == 0);
      clr_a     = ($urandom_range(0, 59) == 0);
      tick_a();
    end
    halt_a = 0; clr_a = 0; rd_en_a = 0;

    // Reset mid-run with a read pending
    clr_a = 1; tick_a(); clr_a = 0;
    ev_a = 4'b1111;
    repeat (3) tick_a();
    ev_a = '0; rst_n_a = 0; rd_en_a = 1; rd_addr_a = 3'd4;
    tick_a();
    check("rst_mid_vld",  32'(rd_vld_a),  32'd0);
    check("rst_mid_data", 32'(rd_data_a), 32'd0);
    rst_n_a = 1; rd_en_a = 0;
    tick_a();
    read_a(4, 1); read_a(0, 0);

    // Watchdog on dut_b
    tick_b();
    rst_n_b = 1; ev_b = 4'hF;
    repeat (19) tick_b();
    check("wd_before", 32'(timeout_b), 32'd0);
    tick_b();
    check("wd_timeout", 32'(timeout_b), 32'd1);
    check("wd_not_halt", 32'(halted_b), 32'd0);
    repeat (3) tick_b();
    ev_b = '0;
    read_b(4, 20); read_b(0, 20);

    // Halt coinciding with the watchdog hit
    rst_n_b = 0; tick_b(); rst_n_b = 1;
    check("b_rst_timeout", 32'(timeout_b), 32'd0);
    repeat (19) tick_b();
    halt_b = 1; tick_b(); halt_b = 0;
    check("wd_halt_wins", 32'(halted_b), 32'd1);
    check("wd_halt_no_to", 32'(timeout_b), 32'd0);
    repeat (3) tick_b();
    read_b(4, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
